// File: rtl/nios_led3_btn_dbpio.sv
// Avalon-MM push-button PIO: per-channel synchroniser, counter debouncer,
// selectable rise/fall edge capture with write-1-to-clear, and a level irq.
module nios_led3_btn_dbpio #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [31:0]      readdata_o,
    output logic             irq_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync1_q, sync2_q, stable, prev_q;
    logic [WIDTH-1:0] mask_q, mask_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] cap_q, cap_d, set_edge, wdata;
    logic [31:0]      rdata_d;
    logic             wr, wr_mask, wr_cap, wr_rise, wr_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic st_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) st_q <= 1'b0;
                else          st_q <= sync2_q[i];
            end
            assign stable[i] = st_q;
        end else begin : g_deb
            logic            st_q, st_d;
            logic [CntW-1:0] cnt_q, cnt_d;

            // Counter tracks consecutive cycles of disagreement; it never wraps
            // because it clears at DEBOUNCE_CYCLES-1 when the new level is taken.
            always_comb begin
                st_d  = st_q;
                cnt_d = '0;
                if (sync2_q[i] != st_q) begin
                    if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) st_d  = sync2_q[i];
                    else                                    cnt_d = cnt_q + CntW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    st_q  <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    st_q  <= st_d;
                    cnt_q <= cnt_d;
                end
            end
            assign stable[i] = st_q;
        end
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata_i[31:WIDTH];
    end

    always_comb begin
        wdata     = writedata_i[WIDTH-1:0];
        wr        = chipselect_i & ~write_n_i;
        wr_mask   = wr && (address_i == 3'd2);
        wr_cap    = wr && (address_i == 3'd3);
        wr_rise   = wr && (address_i == 3'd4);
        wr_fall   = wr && (address_i == 3'd5);
        set_edge  = (stable & ~prev_q & rise_en_q) | (~stable & prev_q & fall_en_q);
        // Set is OR-ed after the clear so a same-cycle edge is never lost.
        cap_d     = (cap_q & ~(wr_cap ? wdata : '0)) | set_edge;
        mask_d    = wr_mask ? wdata : mask_q;
        rise_en_d = wr_rise ? wdata : rise_en_q;
        fall_en_d = wr_fall ? wdata : fall_en_q;
    end

    always_comb begin
        rdata_d = '0;
        case (address_i)
            3'd0:    rdata_d[WIDTH-1:0] = stable;
            3'd2:    rdata_d[WIDTH-1:0] = mask_q;
            3'd3:    rdata_d[WIDTH-1:0] = cap_q;
            3'd4:    rdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    rdata_d[WIDTH-1:0] = fall_en_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '1;
            readdata_o <= '0;
        end else begin
            prev_q     <= stable;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_o <= rdata_d;
        end
    end

    assign irq_o = |(cap_q & mask_q);

endmodule
